// File: rtl/pipeline_controller.sv
// pipeline_controller
//   Hazard detection, data-memory stall sequencing and branch flush control
//   for a five-stage pipeline. It also keeps two saturating performance
//   counters.
//
// Parameters
//   MEM_WAIT  cycles the pipe is frozen per data-memory access (1..15)
//   CNT_W     width of each performance counter
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   id_src1/2, id_use_src1/2      source registers read by the ID instruction
//   exe_wb_en, exe_dest           EXE writeback target
//   exe_mem_r_en                  EXE instruction is a load
//   mem_wb_en, mem_dest           MEM writeback target
//   mem_r_en, mem_w_en            MEM instruction accesses data memory
//   forward_en                    forwarding unit enabled
//   branch_taken                  EXE branch resolved taken
//   freeze_if/id/exe/mem          hold the corresponding pipe register
//   flush_if                      zero the IF register
//   bubble_id                     load a NOP into the ID/EXE register
//   mem_stall                     data-memory access in progress
//   hazard_count                  cycles with bubble_id asserted
//   mem_stall_count               cycles with mem_stall asserted
//
// Memory FSM
//   state  | meaning
//   IDLE   | no access in flight; a request stalls this cycle and starts ACCESS
//   ACCESS | access in flight; cnt counts stalled cycles, cnt==MEM_WAIT releases
module pipeline_controller #(
  parameter int unsigned MEM_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             exe_wb_en,
  input  logic [3:0]       exe_dest,
  input  logic             exe_mem_r_en,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             forward_en,
  input  logic             branch_taken,
  output logic             freeze_if,
  output logic             freeze_id,
  output logic             freeze_exe,
  output logic             freeze_mem,
  output logic             flush_if,
  output logic             bubble_id,
  output logic             mem_stall,
  output logic [CNT_W-1:0] hazard_count,
  output logic [CNT_W-1:0] mem_stall_count
);

  localparam logic [3:0]       MEM_WAIT_C = 4'(MEM_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] hazard_count_q, hazard_count_d;
  logic [CNT_W-1:0] mem_stall_count_q, mem_stall_count_d;

  logic raw_exe;
  logic raw_mem;
  logic hazard;
  logic mem_req;

  assign mem_req = mem_r_en | mem_w_en;

  // With forwarding only a load in EXE cannot be bypassed in time; without
  // forwarding every in-flight writer to a source register is a hazard.
  always_comb begin
    raw_exe = exe_wb_en & ((id_use_src1 & (id_src1 == exe_dest)) |
                           (id_use_src2 & (id_src2 == exe_dest)));
    raw_mem = mem_wb_en & ((id_use_src1 & (id_src1 == mem_dest)) |
                           (id_use_src2 & (id_src2 == mem_dest)));
    hazard  = forward_en ? (raw_exe & exe_mem_r_en) : (raw_exe | raw_mem);
  end

  // State register and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      cnt_q             <= 4'd0;
      hazard_count_q    <= '0;
      mem_stall_count_q <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      hazard_count_q    <= hazard_count_d;
      mem_stall_count_q <= mem_stall_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          state_d = ST_ACCESS;
          cnt_d   = 4'd1;
        end
      end
      ST_ACCESS: begin
        // The release cycle returns to IDLE even if a request is still
        // presented; that request belongs to the next instruction.
        if (cnt_q == MEM_WAIT_C) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    mem_stall = 1'b0;
    unique case (state_q)
      ST_IDLE:   mem_stall = mem_req;
      ST_ACCESS: mem_stall = (cnt_q != MEM_WAIT_C);
      default:   mem_stall = 1'b0;
    endcase

    freeze_mem = mem_stall;
    freeze_exe = mem_stall;
    freeze_if  = mem_stall | hazard;
    freeze_id  = mem_stall | hazard;
    // A taken branch waits in the frozen EXE stage and flushes on release.
    // Flush beats bubble: the wrong-path ID instruction is discarded anyway.
    flush_if   = branch_taken & ~mem_stall;
    bubble_id  = hazard & ~mem_stall & ~branch_taken;
  end

  // Saturating performance counters
  always_comb begin
    hazard_count_d    = hazard_count_q;
    mem_stall_count_d = mem_stall_count_q;
    if (bubble_id && (hazard_count_q != CNT_MAX)) begin
      hazard_count_d = hazard_count_q + CNT_ONE;
    end
    if (mem_stall && (mem_stall_count_q != CNT_MAX)) begin
      mem_stall_count_d = mem_stall_count_q + CNT_ONE;
    end
  end

  assign hazard_count    = hazard_count_q;
  assign mem_stall_count = mem_stall_count_q;

endmodule
